// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, VGA read port, shared-memory port and grant.
// The arbiter takes the slave modport; requesters/memory side take master.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    logic        vga_req;
    logic [31:0] vga_addr;
    logic [31:0] vga_rdata;
    logic        vga_ack;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [1:0]  grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  vga_req, vga_addr,
        output vga_rdata, vga_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output vga_req, vga_addr,
        input  vga_rdata, vga_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU read/write, VGA read) arbiter for one shared memory, IDLE/ISSUE/WAIT/RESP.
// Ties are round-robin; define VGA_PRIO_EN to make VGA win every tie instead.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_VGA  = 2'b10;
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] vga_rdata_q, vga_rdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        tie_to_vga;
    logic        pick_vga;

`ifdef VGA_PRIO_EN
    assign tie_to_vga = 1'b1;
`else
    // Set when VGA held the last grant, so the CPU takes the next tie.
    logic last_vga_q, last_vga_d;
    assign tie_to_vga = ~last_vga_q;
`endif

    assign pick_vga = bus.vga_req & (~bus.cpu_req | tie_to_vga);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        cnt_d       = cnt_q;
`ifndef VGA_PRIO_EN
        last_vga_d  = last_vga_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cpu_req | bus.vga_req) begin
                    grant_d = pick_vga ? GNT_VGA : GNT_CPU;
                    addr_d  = pick_vga ? bus.vga_addr : bus.cpu_addr;
                    we_d    = ~pick_vga & bus.cpu_we;
                    if (!pick_vga) begin
                        wdata_d = bus.cpu_wdata;
                    end
`ifndef VGA_PRIO_EN
                    last_vga_d = pick_vga;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (grant_q == GNT_CPU && !we_q) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                    if (grant_q == GNT_VGA) begin
                        vga_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
            cnt_q       <= '0;
`ifndef VGA_PRIO_EN
            last_vga_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
            cnt_q       <= cnt_d;
`ifndef VGA_PRIO_EN
            last_vga_q  <= last_vga_d;
`endif
        end
    end

    // Strobes decode straight from state so reset clears them without a cycle of delay.
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) & we_q;
    assign bus.cpu_ready = (state_q == RESP) & (grant_q == GNT_CPU);
    assign bus.vga_ack   = (state_q == RESP) & (grant_q == GNT_VGA);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4, each with a latency-accurate memory model.
module tb_mem_arbiter;

    localparam logic [31:0] BAD_DATA = 32'hBAD0BAD0;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   ka;
    int   kb;
    logic [31:0] da;
    logic [31:0] db;

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.MEM_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mem_arbiter #(.MEM_LAT(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // Data is valid only for the cycle in which it must be captured.
    always @(negedge clk) begin
        if (ka > 0) begin
            ka = ka - 1;
            ifa.mem_rdata = (ka == 0) ? da : BAD_DATA;
        end else begin
            ifa.mem_rdata = BAD_DATA;
        end
        if (ifa.mem_en) begin
            ka = 1;
            da = mem_val(ifa.mem_addr);
        end
    end

    always @(negedge clk) begin
        if (kb > 0) begin
            kb = kb - 1;
            ifb.mem_rdata = (kb == 0) ? db : BAD_DATA;
        end else begin
            ifb.mem_rdata = BAD_DATA;
        end
        if (ifb.mem_en) begin
            kb = 4;
            db = mem_val(ifb.mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tie(input logic vga_first, input logic [31:0] ca, input logic [31:0] va);
        logic [1:0]  g1;
        logic [1:0]  g2;
        logic [31:0] a1;
        logic [31:0] a2;
        g1 = vga_first ? 2'b10 : 2'b01;
        g2 = vga_first ? 2'b01 : 2'b10;
        a1 = vga_first ? va : ca;
        a2 = vga_first ? ca : va;
        ifa.cpu_we   = 1'b0;
        ifa.cpu_addr = ca;
        ifa.vga_addr = va;
        ifa.cpu_req  = 1'b1;
        ifa.vga_req  = 1'b1;
        @(negedge clk);
        chk("tie_grant1", 32'(ifa.grant), 32'(g1));
        chk("tie_addr1", ifa.mem_addr, a1);
        repeat (2) @(negedge clk);
        chk("tie_done1", 32'({ifa.vga_ack, ifa.cpu_ready}), 32'(g1));
        if (vga_first) begin
            chk("tie_vdata1", ifa.vga_rdata, mem_val(va));
            ifa.vga_req = 1'b0;
        end else begin
            chk("tie_cdata1", ifa.cpu_rdata, mem_val(ca));
            ifa.cpu_req = 1'b0;
        end
        @(negedge clk);
        chk("tie_gap_grant", 32'(ifa.grant), 32'h0);
        @(negedge clk);
        chk("tie_grant2", 32'(ifa.grant), 32'(g2));
        chk("tie_addr2", ifa.mem_addr, a2);
        repeat (2) @(negedge clk);
        chk("tie_done2", 32'({ifa.vga_ack, ifa.cpu_ready}), 32'(g2));
        chk("tie_cdata", ifa.cpu_rdata, mem_val(ca));
        chk("tie_vdata", ifa.vga_rdata, mem_val(va));
        ifa.cpu_req = 1'b0;
        ifa.vga_req = 1'b0;
        @(negedge clk);
        chk("tie_end_grant", 32'(ifa.grant), 32'h0);
        chk("tie_end_pulse", 32'({ifa.vga_ack, ifa.cpu_ready}), 32'h0);
    endtask

    initial begin
        int   n;
        logic pulse;
        total = 0;
        bad   = 0;
        ka    = 0;
        kb    = 0;
        da    = '0;
        db    = '0;
        ifa.mem_rdata = BAD_DATA;
        ifb.mem_rdata = BAD_DATA;
        ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
        ifa.vga_req = 1'b0; ifa.vga_addr = '0;
        ifb.cpu_req = 1'b0; ifb.cpu_we = 1'b0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
        ifb.vga_req = 1'b0; ifb.vga_addr = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_grant", 32'(ifa.grant), 32'h0);
        chk("rst_strobes", 32'({ifa.cpu_ready, ifa.vga_ack, ifa.mem_en, ifa.mem_we}), 32'h0);
        chk("rst_mem_addr", ifa.mem_addr, 32'h0);
        chk("rst_mem_wdata", ifa.mem_wdata, 32'h0);
        chk("rst_cpu_rdata", ifa.cpu_rdata, 32'h0);
        chk("rst_vga_rdata", ifa.vga_rdata, 32'h0);
        chk("rst_b_grant", 32'(ifb.grant), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", 32'(ifa.mem_en), 32'h0);

`ifdef VGA_PRIO_EN
        tie(1'b1, 32'h0000_0300, 32'h0000_0400);
`else
        tie(1'b0, 32'h0000_0300, 32'h0000_0400);
`endif

        // CPU read; address/we change after capture must not leak into the access.
        ifa.cpu_addr = 32'h0000_0100;
        ifa.cpu_we   = 1'b0;
        ifa.cpu_req  = 1'b1;
        @(negedge clk);
        chk("rd_mem_en", 32'(ifa.mem_en), 32'h1);
        chk("rd_mem_we", 32'(ifa.mem_we), 32'h0);
        chk("rd_mem_addr", ifa.mem_addr, 32'h0000_0100);
        chk("rd_grant", 32'(ifa.grant), 32'h1);
        ifa.cpu_addr = 32'h0000_0999;
        ifa.cpu_we   = 1'b1;
        @(negedge clk);
        chk("rd_en_one_cycle", 32'({ifa.mem_en, ifa.mem_we}), 32'h0);
        chk("rd_ready_early", 32'(ifa.cpu_ready), 32'h0);
        chk("rd_addr_hold", ifa.mem_addr, 32'h0000_0100);
        @(negedge clk);
        chk("rd_ready", 32'(ifa.cpu_ready), 32'h1);
        chk("rd_data", ifa.cpu_rdata, 32'hDEADBEEF);
        chk("rd_vga_ack", 32'(ifa.vga_ack), 32'h0);
        ifa.cpu_req = 1'b0;
        ifa.cpu_we  = 1'b0;
        @(negedge clk);
        chk("rd_ready_pulse", 32'(ifa.cpu_ready), 32'h0);
        chk("rd_grant_clr", 32'(ifa.grant), 32'h0);

        // CPU write.
        ifa.cpu_addr  = 32'h0000_0204;
        ifa.cpu_wdata = 32'h1234_5678;
        ifa.cpu_we    = 1'b1;
        ifa.cpu_req   = 1'b1;
        @(negedge clk);
        chk("wr_strobes", 32'({ifa.mem_en, ifa.mem_we}), 32'h3);
        chk("wr_mem_addr", ifa.mem_addr, 32'h0000_0204);
        chk("wr_mem_wdata", ifa.mem_wdata, 32'h1234_5678);
        ifa.cpu_wdata = 32'h0;
        @(negedge clk);
        chk("wr_strobes_off", 32'({ifa.mem_en, ifa.mem_we}), 32'h0);
        @(negedge clk);
        chk("wr_ready", 32'(ifa.cpu_ready), 32'h1);
        chk("wr_rdata_kept", ifa.cpu_rdata, 32'hDEADBEEF);
        ifa.cpu_req = 1'b0;
        ifa.cpu_we  = 1'b0;
        @(negedge clk);
        chk("wr_wdata_hold", ifa.mem_wdata, 32'h1234_5678);

        // Last grant was CPU, so VGA wins this tie in both builds.
        tie(1'b1, 32'h0000_0308, 32'h0000_0408);

        // MEM_LAT=4 VGA read: ack six cycles after the request is sampled.
        ifb.vga_addr = 32'h0000_0480;
        ifb.vga_req  = 1'b1;
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifb.vga_ack) begin
                n = i;
                break;
            end
        end
        chk("lat4_ack_cycles", 32'(n), 32'd6);
        chk("lat4_vga_data", ifb.vga_rdata, 32'hA5A5_0480);
        ifb.vga_req = 1'b0;
        @(negedge clk);
        chk("lat4_ack_pulse", 32'(ifb.vga_ack), 32'h0);

        // Reset during WAIT aborts the access; the held request is re-served afterwards.
        ifb.cpu_addr = 32'h0000_0500;
        ifb.cpu_we   = 1'b0;
        ifb.cpu_req  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_grant", 32'(ifb.grant), 32'h0);
        chk("abort_strobes", 32'({ifb.cpu_ready, ifb.vga_ack, ifb.mem_en, ifb.mem_we}), 32'h0);
        chk("abort_mem_addr", ifb.mem_addr, 32'h0);
        chk("abort_vga_rdata", ifb.vga_rdata, 32'h0);
        pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifb.cpu_ready) pulse = 1'b1;
        end
        rst = 1'b0;
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifb.cpu_ready) begin
                n = i;
                break;
            end
        end
        chk("abort_no_pulse", 32'(pulse), 32'h0);
        chk("rearb_ready_cycles", 32'(n), 32'd6);
        chk("rearb_cpu_data", ifb.cpu_rdata, 32'hA5A5_0500);
        ifb.cpu_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
